// File: rtl/nzr_pixel_receiver.sv
// NZR (WS2812B-style) serial receiver: classifies high-pulse widths into bits,
// assembles 24-bit GRB words MSB-first and detects the long-low frame RESET.
module nzr_pixel_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 64,
    parameter int MIN_HIGH    = 8,
    parameter int MAX_HIGH    = 110,
    parameter int RESET_LOW   = 28000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_reset,
    output logic        bit_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        WAIT_RST,
        ARMED,
        HIGH
    } state_t;

    localparam logic [6:0]  THRESH_C     = 7'(THRESH);
    localparam logic [6:0]  MIN_HIGH_C   = 7'(MIN_HIGH);
    localparam logic [6:0]  MAX_HIGH_P1  = 7'(MAX_HIGH + 1);
    localparam logic [14:0] RESET_LOW_C  = 15'(RESET_LOW);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   din_q, din_d;
    logic [6:0]             hcnt_q, hcnt_d;
    logic [14:0]            lcnt_q, lcnt_d;
    logic [4:0]             bitcnt_q, bitcnt_d;
    logic [23:0]            shreg_q, shreg_d;
    logic                   word_done_q, word_done_d;
    logic [23:0]            pixel_data_q, pixel_data_d;
    logic                   pixel_valid_q, pixel_valid_d;
    logic [7:0]             pixel_index_q, pixel_index_d;
    logic                   frame_reset_q, frame_reset_d;
    logic                   bit_error_q, bit_error_d;

    logic        din_s;
    logic        rise;
    logic        fall;
    logic [6:0]  hcnt_inc;
    logic [14:0] lcnt_inc;
    logic        lcnt_hit;

    assign din_s = sync_q[SYNC_STAGES-1];
    assign rise  = din_s & ~din_q;
    assign fall  = ~din_s & din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_RST;
            sync_q        <= '0;
            din_q         <= 1'b0;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            word_done_q   <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            frame_reset_q <= 1'b0;
            bit_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            din_q         <= din_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            word_done_q   <= word_done_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            frame_reset_q <= frame_reset_d;
            bit_error_q   <= bit_error_d;
        end
    end

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], din};
        din_d         = din_s;
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bitcnt_d      = bitcnt_q;
        shreg_d       = shreg_q;
        word_done_d   = 1'b0;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_index_d = pixel_index_q;
        frame_reset_d = 1'b0;
        bit_error_d   = 1'b0;

        hcnt_inc = (hcnt_q == 7'd127) ? 7'd127 : hcnt_q + 7'd1;
        lcnt_inc = (lcnt_q >= RESET_LOW_C) ? RESET_LOW_C : lcnt_q + 15'd1;
        // Fires only on the transition into RESET_LOW, so once per low period.
        lcnt_hit = (lcnt_inc == RESET_LOW_C) && (lcnt_q != RESET_LOW_C);

        // The 24th bit was shifted in last cycle; publish the word now.
        if (word_done_q) begin
            pixel_data_d  = shreg_q;
            pixel_valid_d = 1'b1;
            pixel_index_d = pixel_index_q + 8'd1;
            bitcnt_d      = 5'd0;
        end

        case (state_q)
            WAIT_RST: begin
                if (din_s) begin
                    lcnt_d = 15'd0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_hit) begin
                        frame_reset_d = 1'b1;
                        pixel_index_d = 8'd0;
                        state_d       = ARMED;
                    end
                end
            end
            ARMED: begin
                if (rise) begin
                    lcnt_d  = 15'd0;
                    hcnt_d  = 7'd1;
                    state_d = HIGH;
                end else if (!din_s) begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_hit) begin
                        frame_reset_d = 1'b1;
                        pixel_index_d = 8'd0;
                        if (bitcnt_q != 5'd0) begin
                            bit_error_d = 1'b1;
                            bitcnt_d    = 5'd0;
                            shreg_d     = '0;
                        end
                    end
                end
            end
            HIGH: begin
                if (din_s) begin
                    hcnt_d = hcnt_inc;
                    // Stuck-high line: abandon the word and wait for a fresh RESET.
                    if (hcnt_inc == MAX_HIGH_P1) begin
                        bit_error_d = 1'b1;
                        bitcnt_d    = 5'd0;
                        shreg_d     = '0;
                        lcnt_d      = 15'd0;
                        state_d     = WAIT_RST;
                    end
                end else if (fall) begin
                    lcnt_d = 15'd1;
                    if (hcnt_q < MIN_HIGH_C) begin
                        bit_error_d = 1'b1;
                        bitcnt_d    = 5'd0;
                        shreg_d     = '0;
                        state_d     = WAIT_RST;
                    end else begin
                        shreg_d = {shreg_q[22:0], (hcnt_q >= THRESH_C)};
                        state_d = ARMED;
                        if (bitcnt_q == 5'd23) begin
                            word_done_d = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = WAIT_RST;
            end
        endcase
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_index = pixel_index_q;
    assign frame_reset = frame_reset_q;
    assign bit_error   = bit_error_q;
    assign busy        = (bitcnt_q != 5'd0);

endmodule

// File: tb/tb_nzr_pixel_receiver.sv
// Directed bench for nzr_pixel_receiver with a shortened RESET_LOW to keep runtime small.
module tb_nzr_pixel_receiver;

    localparam int RST_LOW = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_reset;
    logic        bit_error;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          n_valid = 0;
    int          n_frame = 0;
    int          n_err   = 0;
    logic [23:0] words[$];
    logic [7:0]  idxs[$];

    always #5 clk = ~clk;

    nzr_pixel_receiver #(
        .SYNC_STAGES(2),
        .THRESH(64),
        .MIN_HIGH(8),
        .MAX_HIGH(110),
        .RESET_LOW(RST_LOW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_index(pixel_index),
        .frame_reset(frame_reset),
        .bit_error(bit_error),
        .busy(busy)
    );

    // Event recorder: sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (pixel_valid === 1'b1) begin
            n_valid++;
            words.push_back(pixel_data);
            idxs.push_back(pixel_index);
        end
        if (frame_reset === 1'b1) n_frame++;
        if (bit_error === 1'b1) n_err++;
    end

    task automatic clear_counts();
        n_valid = 0;
        n_frame = 0;
        n_err   = 0;
        words.delete();
        idxs.delete();
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(92, 33);
        else   send_pulse(36, 89);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic wait_frame(input int limit, output logic seen, output logic err_same,
                              output logic busy_before);
        logic busy_prev;
        seen = 1'b0;
        err_same = 1'b0;
        busy_before = 1'b0;
        din = 1'b0;
        for (int i = 0; i < limit; i++) begin
            busy_prev = busy;
            @(negedge clk);
            if (frame_reset === 1'b1) begin
                seen = 1'b1;
                err_same = bit_error;
                busy_before = busy_prev;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int t;
        reset = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pixel_data, pixel_valid, pixel_index, frame_reset, bit_error, busy} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pixel_data, pixel_valid, pixel_index, frame_reset, bit_error, busy});
        end
        reset = 1'b0;
        clear_counts();
        t = -1;
        for (int i = 1; i <= RST_LOW + 10; i++) begin
            @(negedge clk);
            if (frame_reset === 1'b1) begin
                t = i;
                break;
            end
        end
        checks++;
        if (t !== RST_LOW) begin
            errors++;
            $display("FAIL frame_latency: got %0d expected %0d", t, RST_LOW);
        end
        checks++;
        if (pixel_index !== 8'd0 || bit_error !== 1'b0) begin
            errors++;
            $display("FAIL frame_idx_err: got idx=%0d err=%b expected idx=0 err=0", pixel_index, bit_error);
        end
        @(negedge clk);
        checks++;
        if (frame_reset !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse_width: got %b expected 0", frame_reset);
        end
    endtask

    task automatic test_single_word();
        logic [23:0] w;
        w = 24'hA5C30F;
        clear_counts();
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        din = 1'b1;
        repeat (w[0] ? 92 : 36) @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b expected 0", pixel_valid);
        end
        @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b1 || pixel_data !== 24'hA5C30F || pixel_index !== 8'd1) begin
            errors++;
            $display("FAIL single_word: got v=%b d=%h i=%0d expected v=1 d=a5c30f i=1",
                     pixel_valid, pixel_data, pixel_index);
        end
        idle(30);
        checks++;
        if (n_valid !== 1 || n_err !== 0 || n_frame !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_counts: got v=%0d e=%0d f=%0d busy=%b expected 1 0 0 0",
                     n_valid, n_err, n_frame, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic seen, err_same, busy_before;
        idle(RST_LOW + 20);
        clear_counts();
        send_word(24'h00FF00);
        send_word(24'hFFFFFF);
        send_word(24'h000000);
        wait_frame(RST_LOW + 50, seen, err_same, busy_before);
        checks++;
        if (n_valid !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", n_valid);
        end else begin
            checks++;
            if (words[0] !== 24'h00FF00 || words[1] !== 24'hFFFFFF || words[2] !== 24'h000000) begin
                errors++;
                $display("FAIL b2b_words: got %h %h %h expected 00ff00 ffffff 000000",
                         words[0], words[1], words[2]);
            end
            checks++;
            if (idxs[0] !== 8'd1 || idxs[1] !== 8'd2 || idxs[2] !== 8'd3) begin
                errors++;
                $display("FAIL b2b_index: got %0d %0d %0d expected 1 2 3", idxs[0], idxs[1], idxs[2]);
            end
        end
        checks++;
        if (seen !== 1'b1 || pixel_index !== 8'd0 || err_same !== 1'b0 || n_err !== 0) begin
            errors++;
            $display("FAIL b2b_frame: got seen=%b idx=%0d err=%b nerr=%0d expected 1 0 0 0",
                     seen, pixel_index, err_same, n_err);
        end
        idle(10);
    endtask

    task automatic test_width_bounds();
        logic [19:0] rest;
        rest = 20'hABCDE;
        clear_counts();
        send_pulse(63, 60);
        send_pulse(64, 60);
        send_pulse(8, 60);
        send_pulse(110, 60);
        for (int i = 19; i >= 0; i--) send_bit(rest[i]);
        idle(20);
        checks++;
        if (n_valid !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL width_count: got v=%0d e=%0d expected 1 0", n_valid, n_err);
        end else begin
            checks++;
            if (words[0] !== 24'h5ABCDE) begin
                errors++;
                $display("FAIL width_word: got %h expected 5abcde", words[0]);
            end
        end

        clear_counts();
        send_bit(1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_pre: got %b expected 1", busy);
        end
        send_pulse(7, 60);
        checks++;
        if (n_err !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_error: got e=%0d busy=%b expected 1 0", n_err, busy);
        end
        send_word(24'h111111);
        idle(20);
        checks++;
        if (n_valid !== 0 || n_err !== 1) begin
            errors++;
            $display("FAIL glitch_ignored: got v=%0d e=%0d expected 0 1", n_valid, n_err);
        end
        idle(RST_LOW + 20);
        checks++;
        if (n_frame !== 1 || n_err !== 1) begin
            errors++;
            $display("FAIL glitch_rearm: got f=%0d e=%0d expected 1 1", n_frame, n_err);
        end

        clear_counts();
        send_bit(1'b1);
        send_bit(1'b0);
        din = 1'b1;
        repeat (112) @(negedge clk);
        checks++;
        if (n_err !== 0) begin
            errors++;
            $display("FAIL overlong_early: got %0d expected 0", n_err);
        end
        @(negedge clk);
        checks++;
        if (bit_error !== 1'b1) begin
            errors++;
            $display("FAIL overlong_error: got %b expected 1", bit_error);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (n_err !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overlong_state: got e=%0d busy=%b expected 1 0", n_err, busy);
        end
        idle(60);
        send_word(24'h222222);
        idle(20);
        checks++;
        if (n_valid !== 0 || n_err !== 1) begin
            errors++;
            $display("FAIL overlong_ignored: got v=%0d e=%0d expected 0 1", n_valid, n_err);
        end
        idle(RST_LOW + 20);
    endtask

    task automatic test_no_prior_reset();
        reset = 1'b1;
        din = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_counts();
        send_word(24'h654321);
        idle(20);
        checks++;
        if (n_valid !== 0 || n_err !== 0 || n_frame !== 0) begin
            errors++;
            $display("FAIL noreset_ignored: got v=%0d e=%0d f=%0d expected 0 0 0", n_valid, n_err, n_frame);
        end
        idle(RST_LOW + 20);
        checks++;
        if (n_frame !== 1) begin
            errors++;
            $display("FAIL noreset_frame: got %0d expected 1", n_frame);
        end
        clear_counts();
        send_word(24'h654321);
        idle(20);
        checks++;
        if (n_valid !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL noreset_count: got v=%0d e=%0d expected 1 0", n_valid, n_err);
        end else begin
            checks++;
            if (words[0] !== 24'h654321 || idxs[0] !== 8'd1) begin
                errors++;
                $display("FAIL noreset_word: got %h idx=%0d expected 654321 idx=1", words[0], idxs[0]);
            end
        end
    endtask

    task automatic test_partial_word();
        logic [9:0] part;
        logic seen, err_same, busy_before;
        part = 10'h2B5;
        clear_counts();
        for (int i = 9; i >= 0; i--) send_bit(part[i]);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_busy: got %b expected 1", busy);
        end
        wait_frame(RST_LOW + 50, seen, err_same, busy_before);
        checks++;
        if (seen !== 1'b1 || err_same !== 1'b1 || busy_before !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_frame: got seen=%b err=%b busy %b->%b expected 1 1 1->0",
                     seen, err_same, busy_before, busy);
        end
        idle(10);
        clear_counts();
        send_word(24'h123456);
        idle(20);
        checks++;
        if (n_valid !== 1 || n_err !== 0) begin
            errors++;
            $display("FAIL partial_next_count: got v=%0d e=%0d expected 1 0", n_valid, n_err);
        end else begin
            checks++;
            if (words[0] !== 24'h123456 || idxs[0] !== 8'd1) begin
                errors++;
                $display("FAIL partial_next_word: got %h idx=%0d expected 123456 idx=1", words[0], idxs[0]);
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [11:0] part;
        part = 12'hA5A;
        clear_counts();
        for (int i = 11; i >= 0; i--) send_bit(part[i]);
        checks++;
        if (busy !== 1'b1 || pixel_data !== 24'h123456) begin
            errors++;
            $display("FAIL midword_pre: got busy=%b d=%h expected 1 123456", busy, pixel_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pixel_data, pixel_valid, pixel_index, frame_reset, bit_error, busy} !== 36'd0) begin
            errors++;
            $display("FAIL midword_reset: got %h expected 0",
                     {pixel_data, pixel_valid, pixel_index, frame_reset, bit_error, busy});
        end
        reset = 1'b0;
        clear_counts();
        send_word(24'hABCDEF);
        idle(20);
        checks++;
        if (n_valid !== 0 || n_err !== 0 || n_frame !== 0) begin
            errors++;
            $display("FAIL midword_ignored: got v=%0d e=%0d f=%0d expected 0 0 0", n_valid, n_err, n_frame);
        end
        idle(RST_LOW + 20);
        checks++;
        if (n_frame !== 1 || pixel_data !== 24'd0) begin
            errors++;
            $display("FAIL midword_rearm: got f=%0d d=%h expected 1 0", n_frame, pixel_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        din = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_width_bounds();
        test_no_prior_reset();
        test_partial_word();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
